// File: rtl/mips_cpu_lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_definitions                                               |
// | Shared types for the MIPS core load/store unit.                    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mips_cpu_definitions;

    typedef enum logic [3:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_BUS, ST_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE, ERR_MISALIGNED, ERR_TIMEOUT
    } lsu_err_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_lsu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_lsu_if                                                    |
// | Avalon-MM master/slave bundle used by the load/store unit.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mips_cpu_lsu_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]  address;
    logic                   read;
    logic                   write;
    logic                   waitrequest;
    logic [BUS_WIDTH-1:0]   writedata;
    logic [BUS_WIDTH/8-1:0] byteenable;
    logic [BUS_WIDTH-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_lsu_align                                                 |
// | Lane decode: byteenable, store placement, load extend/merge.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mips_cpu_lsu_align
    import mips_cpu_definitions::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  mem_op_t                            op,
    input  logic [$clog2(BUS_WIDTH/8)-1:0]     off,
    input  logic [31:0]                        wdata,
    input  logic [31:0]                        rt_old,
    input  logic [BUS_WIDTH-1:0]               readdata,
    output logic [BUS_WIDTH/8-1:0]             byteenable,
    output logic [BUS_WIDTH-1:0]               writedata,
    output logic [31:0]                        ldata,
    output logic                               misaligned
);
    localparam int LANES = BUS_WIDTH / 8;
    localparam int OFFS  = $clog2(LANES);

    logic [OFFS-1:0] w_wbase;
    logic [1:0]      w_o;
    logic [31:0]     w_m;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [4:0]      w_sl;
    logic [4:0]      w_sr;

    // Lane index of the first byte of the addressed 32-bit word
    generate
        if (OFFS > 2) begin : g_wide
            assign w_wbase = {off[OFFS-1:2], 2'b00};
        end else begin : g_narrow
            assign w_wbase = '0;
        end
    endgenerate

    assign w_o    = off[1:0];
    assign w_m    = readdata[{w_wbase, 3'b000} +: 32];
    assign w_byte = w_m[{w_o, 3'b000} +: 8];
    assign w_half = w_m[{w_o[1], 4'b0000} +: 16];
    assign w_sl   = {2'd3 - w_o, 3'b000};
    assign w_sr   = {w_o, 3'b000};

    always_comb begin
        byteenable = '0;
        writedata  = '0;
        ldata      = '0;
        misaligned = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_SB: byteenable = LANES'(1) << off;
            OP_LH, OP_LHU, OP_SH: begin
                byteenable = LANES'(3) << off;
                misaligned = off[0];
            end
            OP_LW, OP_SW: begin
                byteenable = LANES'(4'hF) << off;
                misaligned = (w_o != 2'd0);
            end
            OP_LWL:  byteenable = LANES'(4'((5'd2 << w_o) - 5'd1)) << w_wbase;
            OP_LWR:  byteenable = LANES'(4'(4'hF << w_o)) << w_wbase;
            default: byteenable = '0;
        endcase
        case (op)
            OP_SB:   writedata = BUS_WIDTH'(wdata[7:0])  << {off, 3'b000};
            OP_SH:   writedata = BUS_WIDTH'(wdata[15:0]) << {off, 3'b000};
            OP_SW:   writedata = BUS_WIDTH'(wdata)       << {off, 3'b000};
            default: writedata = '0;
        endcase
        case (op)
            OP_LB:   ldata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  ldata = {24'd0, w_byte};
            OP_LH:   ldata = {{16{w_half[15]}}, w_half};
            OP_LHU:  ldata = {16'd0, w_half};
            OP_LW:   ldata = w_m;
            // Unaligned merges keep the rt bytes not covered by memory
            OP_LWL:  ldata = (w_m << w_sl) | (rt_old & ~(32'hFFFF_FFFF << w_sl));
            OP_LWR:  ldata = (w_m >> w_sr) | (rt_old & ~(32'hFFFF_FFFF >> w_sr));
            default: ldata = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mips_cpu_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_lsu                                                       |
// | Load/store unit: Avalon-MM master of the multicycle MIPS core.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mips_cpu_lsu
    import mips_cpu_definitions::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  mem_op_t               req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_rt_old,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output lsu_err_t              resp_err,
    mips_cpu_lsu_if.master        bus
);
    localparam int LANES = BUS_WIDTH / 8;
    localparam int OFFS  = $clog2(LANES);
    localparam int CW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    lsu_state_t             r_state, w_state_next;
    mem_op_t                r_op, w_op_sel;
    logic [OFFS-1:0]        r_off, w_off_sel;
    logic [31:0]            r_rt_old;
    logic [CW-1:0]          r_wait_cnt;
    logic [ADDR_WIDTH-1:0]  r_address;
    logic                   r_read, r_write;
    logic [BUS_WIDTH-1:0]   r_writedata;
    logic [LANES-1:0]       r_byteenable;
    logic [31:0]            r_resp_rdata;
    lsu_err_t               r_resp_err;
    logic                   w_accept, w_bus_done, w_timeout, w_misaligned;
    logic [LANES-1:0]       w_be;
    logic [BUS_WIDTH-1:0]   w_wdata;
    logic [31:0]            w_ldata;

    // Decode the incoming request while idle, the held op afterwards
    assign w_op_sel  = (r_state == ST_IDLE) ? req_op : r_op;
    assign w_off_sel = (r_state == ST_IDLE) ? req_addr[OFFS-1:0] : r_off;

    mips_cpu_lsu_align #(.BUS_WIDTH(BUS_WIDTH)) u_align (
        .op         (w_op_sel),
        .off        (w_off_sel),
        .wdata      (req_wdata),
        .rt_old     (r_rt_old),
        .readdata   (bus.readdata),
        .byteenable (w_be),
        .writedata  (w_wdata),
        .ldata      (w_ldata),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bus_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: if (req_valid) begin
                w_accept     = 1'b1;
                w_state_next = w_misaligned ? ST_DONE : ST_BUS;
            end
            ST_BUS: if (!bus.waitrequest) begin
                w_bus_done   = 1'b1;
                w_state_next = ST_DONE;
            end else if ((MAX_WAIT != 0) && (r_wait_cnt == CW'(MAX_WAIT))) begin
                w_timeout    = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op         <= OP_LB;
            r_off        <= '0;
            r_rt_old     <= '0;
            r_wait_cnt   <= '0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= ERR_NONE;
        end else begin
            if (w_accept) begin
                r_op       <= req_op;
                r_off      <= req_addr[OFFS-1:0];
                r_rt_old   <= req_rt_old;
                r_wait_cnt <= '0;
                if (w_misaligned) begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= ERR_MISALIGNED;
                end else begin
                    r_address    <= {req_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
                    r_read       <= !is_store(req_op);
                    r_write      <= is_store(req_op);
                    r_byteenable <= w_be;
                    r_writedata  <= w_wdata;
                end
            end
            if (r_state == ST_BUS) begin
                if (w_bus_done) begin
                    r_read       <= 1'b0;
                    r_write      <= 1'b0;
                    r_resp_rdata <= is_store(r_op) ? 32'd0 : w_ldata;
                    r_resp_err   <= ERR_NONE;
                end else if (w_timeout) begin
                    r_read       <= 1'b0;
                    r_write      <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= ERR_TIMEOUT;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign resp_valid     = (r_state == ST_DONE);
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign bus.address    = r_address;
    assign bus.read       = r_read;
    assign bus.write      = r_write;
    assign bus.writedata  = r_writedata;
    assign bus.byteenable = r_byteenable;
endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mips_cpu_lsu                                                    |
// | Directed self-checking bench: 32-bit (MAX_WAIT=4) and 64-bit LSU.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mips_cpu_lsu;
    import mips_cpu_definitions::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 32-bit instance
    logic        reset32, req_valid32, req_ready32, resp_valid32;
    mem_op_t     req_op32;
    logic [31:0] req_addr32, req_wdata32, req_rt_old32, resp_rdata32;
    lsu_err_t    resp_err32;
    mips_cpu_lsu_if #(.BUS_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();

    mips_cpu_lsu #(.BUS_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(4)) u_dut32 (
        .clk(clk), .reset(reset32), .req_valid(req_valid32), .req_ready(req_ready32),
        .req_op(req_op32), .req_addr(req_addr32), .req_wdata(req_wdata32),
        .req_rt_old(req_rt_old32), .resp_valid(resp_valid32), .resp_rdata(resp_rdata32),
        .resp_err(resp_err32), .bus(bus32)
    );

    // 64-bit instance
    logic        reset64, req_valid64, req_ready64, resp_valid64;
    mem_op_t     req_op64;
    logic [31:0] req_addr64, req_wdata64, req_rt_old64, resp_rdata64;
    lsu_err_t    resp_err64;
    mips_cpu_lsu_if #(.BUS_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

    mips_cpu_lsu #(.BUS_WIDTH(64), .ADDR_WIDTH(32), .MAX_WAIT(0)) u_dut64 (
        .clk(clk), .reset(reset64), .req_valid(req_valid64), .req_ready(req_ready64),
        .req_op(req_op64), .req_addr(req_addr64), .req_wdata(req_wdata64),
        .req_rt_old(req_rt_old64), .resp_valid(resp_valid64), .resp_rdata(resp_rdata64),
        .resp_err(resp_err64), .bus(bus64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns #1 after the accept edge
    task automatic issue32(input mem_op_t op, input logic [31:0] addr, wd, rt);
        req_valid32 = 1'b1; req_op32 = op; req_addr32 = addr;
        req_wdata32 = wd; req_rt_old32 = rt;
        @(posedge clk); #1;
        req_valid32 = 1'b0;
    endtask

    task automatic issue64(input mem_op_t op, input logic [31:0] addr, wd);
        req_valid64 = 1'b1; req_op64 = op; req_addr64 = addr;
        req_wdata64 = wd; req_rt_old64 = '0;
        @(posedge clk); #1;
        req_valid64 = 1'b0;
    endtask

    // Zero-wait load on the 32-bit port
    task automatic load32(input string tag, input mem_op_t op, input logic [31:0] addr, rt,
                          input logic [3:0] exp_be, input logic [31:0] exp_rdata);
        issue32(op, addr, 32'd0, rt);
        chk({tag, ".read"}, bus32.read, 1'b1);
        chk({tag, ".write"}, bus32.write, 1'b0);
        chk({tag, ".addr"}, bus32.address, 32'h1000);
        chk({tag, ".be"}, bus32.byteenable, exp_be);
        chk({tag, ".rv_early"}, resp_valid32, 1'b0);
        @(posedge clk); #1;
        chk({tag, ".read_drop"}, bus32.read, 1'b0);
        chk({tag, ".rv"}, resp_valid32, 1'b1);
        chk({tag, ".rdata"}, resp_rdata32, exp_rdata);
        chk({tag, ".err"}, resp_err32, ERR_NONE);
        @(posedge clk); #1;
        chk({tag, ".rv_pulse"}, resp_valid32, 1'b0);
        chk({tag, ".ready"}, req_ready32, 1'b1);
    endtask

    initial begin
        reset32 = 1'b0; reset64 = 1'b0;
        req_valid32 = 1'b0; req_op32 = OP_LW; req_addr32 = '0; req_wdata32 = '0; req_rt_old32 = '0;
        req_valid64 = 1'b0; req_op64 = OP_LW; req_addr64 = '0; req_wdata64 = '0; req_rt_old64 = '0;
        bus32.waitrequest = 1'b0; bus32.readdata = '0;
        bus64.waitrequest = 1'b0; bus64.readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", req_ready32, 1'b1);
        chk("rst.read", bus32.read, 1'b0);
        chk("rst.write", bus32.write, 1'b0);
        chk("rst.addr", bus32.address, 32'd0);
        chk("rst.be", bus32.byteenable, 4'd0);
        chk("rst.rv", resp_valid32, 1'b0);
        chk("rst.rdata", resp_rdata32, 32'd0);
        chk("rst.err", resp_err32, ERR_NONE);
        reset32 = 1'b1; reset64 = 1'b1;
        @(posedge clk); #1;

        bus32.readdata = 32'hAABBCCDD;
        load32("lw",  OP_LW,  32'h1000, 32'h0,        4'hF, 32'hAABBCCDD);
        load32("lb",  OP_LB,  32'h1003, 32'h0,        4'h8, 32'hFFFFFFAA);
        load32("lbu", OP_LBU, 32'h1003, 32'h0,        4'h8, 32'h000000AA);
        load32("lh",  OP_LH,  32'h1002, 32'h0,        4'hC, 32'hFFFFAABB);
        load32("lhu", OP_LHU, 32'h1000, 32'h0,        4'h3, 32'h0000CCDD);
        load32("lwl", OP_LWL, 32'h1001, 32'h11223344, 4'h3, 32'hCCDD3344);
        load32("lwr", OP_LWR, 32'h1001, 32'h11223344, 4'hE, 32'h11AABBCC);

        // SH with three stall cycles
        bus32.waitrequest = 1'b1;
        issue32(OP_SH, 32'h1002, 32'h0000BEEF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus32.waitrequest = 1'b0;
            chk($sformatf("sh.write%0d", i), bus32.write, 1'b1);
            chk($sformatf("sh.read%0d", i), bus32.read, 1'b0);
            chk($sformatf("sh.be%0d", i), bus32.byteenable, 4'hC);
            chk($sformatf("sh.wd%0d", i), bus32.writedata, 32'hBEEF0000);
            chk($sformatf("sh.rv%0d", i), resp_valid32, 1'b0);
            @(posedge clk); #1;
        end
        chk("sh.write_drop", bus32.write, 1'b0);
        chk("sh.rv", resp_valid32, 1'b1);
        chk("sh.rdata", resp_rdata32, 32'd0);
        chk("sh.err", resp_err32, ERR_NONE);
        @(posedge clk); #1;
        chk("sh.rv_pulse", resp_valid32, 1'b0);

        // Misaligned LW: no bus cycle, response right after accept
        issue32(OP_LW, 32'h1002, 32'h0, 32'h0);
        chk("mis.read", bus32.read, 1'b0);
        chk("mis.write", bus32.write, 1'b0);
        chk("mis.rv", resp_valid32, 1'b1);
        chk("mis.err", resp_err32, ERR_MISALIGNED);
        chk("mis.rdata", resp_rdata32, 32'd0);
        @(posedge clk); #1;
        chk("mis.rv_pulse", resp_valid32, 1'b0);
        chk("mis.ready", req_ready32, 1'b1);

        // Stuck slave: MAX_WAIT=4 gives five bus cycles then TIMEOUT
        bus32.waitrequest = 1'b1;
        issue32(OP_LW, 32'h1000, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("to.read%0d", i), bus32.read, 1'b1);
            chk($sformatf("to.rv%0d", i), resp_valid32, 1'b0);
            @(posedge clk); #1;
        end
        chk("to.read_drop", bus32.read, 1'b0);
        chk("to.rv", resp_valid32, 1'b1);
        chk("to.err", resp_err32, ERR_TIMEOUT);
        chk("to.rdata", resp_rdata32, 32'd0);
        bus32.waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("to.ready", req_ready32, 1'b1);

        // 64-bit bus: SB in the upper word, LW from the upper word
        issue64(OP_SB, 32'h1005, 32'h0000007F);
        chk("sb64.write", bus64.write, 1'b1);
        chk("sb64.addr", bus64.address, 32'h1000);
        chk("sb64.be", bus64.byteenable, 8'h20);
        chk("sb64.wd", bus64.writedata, 64'h0000_7F00_0000_0000);
        @(posedge clk); #1;
        chk("sb64.rv", resp_valid64, 1'b1);
        chk("sb64.err", resp_err64, ERR_NONE);
        @(posedge clk); #1;
        bus64.readdata = 64'h11223344_AABBCCDD;
        issue64(OP_LW, 32'h1004, 32'h0);
        chk("lw64.be", bus64.byteenable, 8'hF0);
        @(posedge clk); #1;
        chk("lw64.rv", resp_valid64, 1'b1);
        chk("lw64.rdata", resp_rdata64, 32'h11223344);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a stalled read
        bus64.waitrequest = 1'b1;
        issue64(OP_LW, 32'h1000, 32'h0);
        chk("rst64.read_before", bus64.read, 1'b1);
        #1 reset64 = 1'b0;
        #1;
        chk("rst64.read", bus64.read, 1'b0);
        chk("rst64.ready", req_ready64, 1'b1);
        chk("rst64.rv", resp_valid64, 1'b0);
        @(posedge clk); #1;
        reset64 = 1'b1;
        bus64.waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("rst64.no_resp", resp_valid64, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
